// File: rtl/dct_row_butterfly_pkg.sv
// Shared widths and types for the MJPEG DCT path, imported by the row
// butterfly and the distributed-arithmetic stages.
package mjpeg_dct_pkg;

  localparam int PIX_W       = 8;
  localparam int DCT_W       = 12;
  localparam int DCT_N       = 8;
  localparam int LEVEL_SHIFT = 128;
  localparam int SMP_W       = PIX_W + 1;
  localparam int CNT_W       = $clog2(DCT_N);

  typedef logic signed [DCT_W-1:0] dct_coef_t;
  typedef logic signed [SMP_W-1:0] dct_smp_t;

endpackage

// File: rtl/dct_row_butterfly_if.sv
// Pixel stream in, butterfly operand bundle out, for the DCT row front end.
interface dct_row_butterfly_if;
  import mjpeg_dct_pkg::*;

  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             blk_sync;
  dct_coef_t        X0, X1, X2, X3;
  dct_coef_t        D0, D1, D2, D3;
  logic             DA_start;
  logic [CNT_W-1:0] row_idx;
  logic             blk_end;

  modport master (
    output pix_data, pix_valid, blk_sync,
    input  X0, X1, X2, X3, D0, D1, D2, D3, DA_start, row_idx, blk_end
  );

  modport slave (
    input  pix_data, pix_valid, blk_sync,
    output X0, X1, X2, X3, D0, D1, D2, D3, DA_start, row_idx, blk_end
  );

endinterface

// File: rtl/dct_row_butterfly_bfly.sv
// Combinational 8-point butterfly: s_k = x_k + x_(7-k), d_k = x_k - x_(7-k),
// widened to the DCT operand width.
module bfly_addsub4
  import mjpeg_dct_pkg::*;
(
  input  dct_smp_t  x [DCT_N],
  output dct_coef_t s [DCT_N/2],
  output dct_coef_t d [DCT_N/2]
);

  function automatic dct_coef_t sext_op(input logic signed [SMP_W:0] v);
    return {{(DCT_W-SMP_W-1){v[SMP_W]}}, v};
  endfunction

  for (genvar k = 0; k < DCT_N/2; k++) begin : g_bf
    logic signed [SMP_W:0] a_w, b_w, sum_w, dif_w;

    // One guard bit is enough: |x| <= 128 so |x_a +/- x_b| <= 256.
    assign a_w   = {x[k][SMP_W-1], x[k]};
    assign b_w   = {x[DCT_N-1-k][SMP_W-1], x[DCT_N-1-k]};
    assign sum_w = a_w + b_w;
    assign dif_w = a_w - b_w;
    assign s[k]  = sext_op(sum_w);
    assign d[k]  = sext_op(dif_w);
  end

endmodule

// File: rtl/dct_row_butterfly.sv
// Row collector for the 8-point DCT: level-shifts pixels, gathers 8 per row
// and presents registered butterfly sums/differences with a DA_start pulse.
module dct_row_butterfly
  import mjpeg_dct_pkg::*;
(
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  dct_row_butterfly_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(DCT_N-1);

  function automatic dct_smp_t level_shift(input logic [PIX_W-1:0] p);
    return $signed({1'b0, p}) - dct_smp_t'(LEVEL_SHIFT);
  endfunction

  logic [CNT_W-1:0] cnt_smp_p0, row_cnt_p0;
  dct_smp_t         smp_p0 [DCT_N-1];
  dct_smp_t         x_in;
  dct_smp_t         vec [DCT_N];
  dct_coef_t        s_w [DCT_N/2];
  dct_coef_t        d_w [DCT_N/2];
  logic             upd;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;

  dct_coef_t        x_p1 [DCT_N/2];
  dct_coef_t        d_p1 [DCT_N/2];
  logic             vld_p1;
  logic             end_p1;
  logic [CNT_W-1:0] row_p1;

  assign x_in   = level_shift(bus.pix_data);
  // A resync beats a row completion, so the 8th sample never updates then.
  assign upd    = bus.pix_valid && !bus.blk_sync && (cnt_smp_p0 == LAST_SMP);
  assign wr_en  = bus.pix_valid && (bus.blk_sync || (cnt_smp_p0 != LAST_SMP));
  assign wr_idx = bus.blk_sync ? '0 : cnt_smp_p0;

  always_comb begin
    for (int i = 0; i < DCT_N-1; i++) vec[i] = smp_p0[i];
    vec[DCT_N-1] = x_in;
  end

  bfly_addsub4 u_bfly (
    .x (vec),
    .s (s_w),
    .d (d_w)
  );

  // p0: sample collection and counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_smp_p0 <= '0;
      row_cnt_p0 <= '0;
      for (int i = 0; i < DCT_N-1; i++) smp_p0[i] <= '0;
    end else begin
      if (bus.blk_sync) begin
        cnt_smp_p0 <= bus.pix_valid ? CNT_W'(1) : '0;
        row_cnt_p0 <= '0;
      end else if (bus.pix_valid) begin
        cnt_smp_p0 <= cnt_smp_p0 + 1'b1;
        if (upd) row_cnt_p0 <= row_cnt_p0 + 1'b1;
      end
      for (int i = 0; i < DCT_N-1; i++)
        if (wr_en && (wr_idx == CNT_W'(i))) smp_p0[i] <= x_in;
    end
  end

  // p1: held butterfly operands and row pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p1 <= 1'b0;
      end_p1 <= 1'b0;
      row_p1 <= '0;
      for (int k = 0; k < DCT_N/2; k++) begin
        x_p1[k] <= '0;
        d_p1[k] <= '0;
      end
    end else begin
      vld_p1 <= upd;
      end_p1 <= upd && (row_cnt_p0 == LAST_SMP);
      if (upd) begin
        row_p1 <= row_cnt_p0;
        for (int k = 0; k < DCT_N/2; k++) begin
          x_p1[k] <= s_w[k];
          d_p1[k] <= d_w[k];
        end
      end
    end
  end

  assign bus.X0       = x_p1[0];
  assign bus.X1       = x_p1[1];
  assign bus.X2       = x_p1[2];
  assign bus.X3       = x_p1[3];
  assign bus.D0       = d_p1[0];
  assign bus.D1       = d_p1[1];
  assign bus.D2       = d_p1[2];
  assign bus.D3       = d_p1[3];
  assign bus.DA_start = vld_p1;
  assign bus.row_idx  = row_p1;
  assign bus.blk_end  = end_p1;

endmodule

// File: tb/tb_dct_row_butterfly.sv
// Directed bench for dct_row_butterfly with hand-computed butterfly results.
module tb_dct_row_butterfly;
  import mjpeg_dct_pkg::*;

  logic sys_clk;
  logic sys_rst_n;
  dct_row_butterfly_if bus ();

  dct_row_butterfly dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk;
  int n_fail;
  int pulses;
  int ends;
  int end_row;
  int row_q[$];

  always @(negedge sys_clk) begin
    if (bus.DA_start) begin
      pulses++;
      row_q.push_back(int'(bus.row_idx));
    end
    if (bus.blk_end) begin
      ends++;
      end_row = int'(bus.row_idx);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_x(input int k);
    case (k)
      0: return int'(bus.X0);
      1: return int'(bus.X1);
      2: return int'(bus.X2);
      default: return int'(bus.X3);
    endcase
  endfunction

  function automatic int get_d(input int k);
    case (k)
      0: return int'(bus.D0);
      1: return int'(bus.D1);
      2: return int'(bus.D2);
      default: return int'(bus.D3);
    endcase
  endfunction

  task automatic check_xd(input string tag, input int es[4], input int ed[4]);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_X%0d", tag, k), get_x(k), es[k]);
      check($sformatf("%s_D%0d", tag, k), get_d(k), ed[k]);
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic sync);
    @(negedge sys_clk);
    bus.pix_data  = p;
    bus.pix_valid = 1'b1;
    bus.blk_sync  = sync;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      bus.pix_valid = 1'b0;
      bus.blk_sync  = 1'b0;
    end
  endtask

  task automatic send_row(input logic [7:0] r[8]);
    for (int i = 0; i < 8; i++) drive(r[i], 1'b0);
  endtask

  logic [7:0] flat_r[8]  = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
  logic [7:0] ramp_r[8]  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  logic [7:0] alt_r[8]   = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
  logic [7:0] full_r[8]  = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
  int zero4[4]   = '{0, 0, 0, 0};
  int ramp_s[4]  = '{-249, -249, -249, -249};
  int ramp_d[4]  = '{-7, -5, -3, -1};
  int alt_s[4]   = '{-1, -1, -1, -1};
  int alt_d[4]   = '{-255, 255, -255, 255};
  int full_s[4]  = '{254, 254, 254, 254};

  int pc0, ec0;

  initial begin
    n_chk = 0; n_fail = 0; pulses = 0; ends = 0; end_row = -1;
    bus.pix_data = '0; bus.pix_valid = 1'b0; bus.blk_sync = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check("rst_DA_start", int'(bus.DA_start), 0);
    check("rst_blk_end", int'(bus.blk_end), 0);
    check("rst_row_idx", int'(bus.row_idx), 0);
    check_xd("rst", zero4, zero4);

    // Row 0: mid-grey gives zero operands
    send_row(flat_r); idle(1); #1;
    check("flat_DA_start", int'(bus.DA_start), 1);
    check("flat_row_idx", int'(bus.row_idx), 0);
    check("flat_blk_end", int'(bus.blk_end), 0);
    check_xd("flat", zero4, zero4);
    idle(1); #1;
    check("flat_pulse_width", int'(bus.DA_start), 0);

    send_row(ramp_r); idle(1); #1;
    check("ramp_DA_start", int'(bus.DA_start), 1);
    check("ramp_row_idx", int'(bus.row_idx), 1);
    check_xd("ramp", ramp_s, ramp_d);

    send_row(alt_r); idle(1); #1;
    check("alt_row_idx", int'(bus.row_idx), 2);
    check_xd("alt", alt_s, alt_d);

    send_row(full_r); idle(1); #1;
    check("full_row_idx", int'(bus.row_idx), 3);
    check_xd("full", full_s, zero4);

    // Ramp with valid gaps of 0..5 cycles
    pc0 = pulses;
    for (int i = 0; i < 7; i++) begin
      drive(ramp_r[i], 1'b0);
      idle(i % 6);
    end
    #1;
    check("gap_no_early_pulse", pulses - pc0, 0);
    check_xd("gap_hold", full_s, zero4);
    drive(ramp_r[7], 1'b0); idle(1); #1;
    check("gap_DA_start", int'(bus.DA_start), 1);
    check("gap_row_idx", int'(bus.row_idx), 4);
    check_xd("gap", ramp_s, ramp_d);

    // 64 consecutive samples after a resync
    pc0 = pulses; ec0 = ends; row_q.delete();
    drive(8'd0, 1'b1);
    for (int i = 1; i < 64; i++) drive(8'(i), 1'b0);
    idle(1); #1;
    check("blk_pulses", pulses - pc0, 8);
    check("blk_ends", ends - ec0, 1);
    check("blk_end_row", end_row, 7);
    for (int i = 0; i < 8; i++)
      check($sformatf("blk_row_seq%0d", i), (i < row_q.size()) ? row_q[i] : -1, i);
    check("blk_last_X0", int'(bus.X0), -137);
    check("blk_last_D0", int'(bus.D0), -7);
    idle(1); #1;
    check("blk_end_width", int'(bus.blk_end), 0);

    // Resync after 3 samples restarts row numbering
    send_row(flat_r); idle(1); #1;
    check("pre_sync_row_idx", int'(bus.row_idx), 0);
    for (int i = 0; i < 3; i++) drive(8'd200, 1'b0);
    @(negedge sys_clk);
    bus.pix_valid = 1'b0; bus.blk_sync = 1'b1;
    pc0 = pulses;
    for (int i = 0; i < 7; i++) drive(ramp_r[i], 1'b0);
    idle(1); #1;
    check("sync3_no_pulse", pulses - pc0, 0);
    drive(ramp_r[7], 1'b0); idle(1); #1;
    check("sync3_DA_start", int'(bus.DA_start), 1);
    check("sync3_row_idx", int'(bus.row_idx), 0);
    check("sync3_X0", int'(bus.X0), -249);

    // Resync with the 8th valid: no pulse, that sample opens the next row
    for (int i = 0; i < 7; i++) drive(8'd255, 1'b0);
    pc0 = pulses;
    drive(8'd0, 1'b1); idle(1); #1;
    check("sync8_no_pulse", pulses - pc0, 0);
    for (int i = 1; i < 8; i++) drive(ramp_r[i], 1'b0);
    idle(1); #1;
    check("sync8_DA_start", int'(bus.DA_start), 1);
    check("sync8_row_idx", int'(bus.row_idx), 0);
    check("sync8_X0", int'(bus.X0), -249);
    check("sync8_D0", int'(bus.D0), -7);

    // Asynchronous reset in the middle of a row
    send_row(full_r); idle(1); #1;
    check("prerst_row_idx", int'(bus.row_idx), 1);
    check("prerst_X0", int'(bus.X0), 254);
    for (int i = 0; i < 3; i++) drive(8'd10, 1'b0);
    @(negedge sys_clk);
    bus.pix_valid = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_X0", int'(bus.X0), 0);
    check("arst_X3", int'(bus.X3), 0);
    check("arst_row_idx", int'(bus.row_idx), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    pc0 = pulses;
    for (int i = 0; i < 7; i++) drive(ramp_r[i], 1'b0);
    idle(1); #1;
    check("arst_no_early_pulse", pulses - pc0, 0);
    drive(ramp_r[7], 1'b0); idle(1); #1;
    check("arst_DA_start", int'(bus.DA_start), 1);
    check("arst_new_row_idx", int'(bus.row_idx), 0);
    check("arst_new_X0", int'(bus.X0), -249);
    check("arst_new_D3", int'(bus.D3), -1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
